// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush/forwarding controller for the 5-stage pipeline. Ports: ID/EX/MEM/WB hazard info and cache misses in; register enables, IF/ID flush, ID/EX bubble, forwarding selects, registered hlt and FSM state out.
module pipe_hazard_ctrl #(
  parameter int RA_W         = 4,
  parameter int BR_STALL_CYC = 1,
  parameter int DRAIN_CYC    = 3,
  parameter int FWD_M2M      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_mem_write,
  input  logic            id_is_cond_branch,
  input  logic            id_is_halt,
  input  logic            branch_taken,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            ex_mem_read,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_dst,
  input  logic            mem_mem_write,
  input  logic [RA_W-1:0] mem_rt,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_dst,
  input  logic            icache_miss,
  input  logic            dcache_miss,
  output logic            pc_wen,
  output logic            ifid_wen,
  output logic            idex_wen,
  output logic            exmem_wen,
  output logic            memwb_wen,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            fwd_mem_data,
  output logic            hlt,
  output logic [1:0]      state
);
  typedef enum logic [1:0] {RUN = 2'b00, BR_WAIT = 2'b01, DRAIN = 2'b10, HALTED = 2'b11} state_t;
  localparam logic       BR0     = (BR_STALL_CYC == 0);
  localparam logic       M2M     = (FWD_M2M != 0);
  localparam logic [3:0] BR_INIT = BR0 ? 4'd0 : 4'(BR_STALL_CYC - 1);
  localparam logic [3:0] DR_INIT = 4'(DRAIN_CYC - 1);
  state_t     st, st_nx;
  logic [3:0] cnt, cnt_nx;
  logic       rflag, rflag_nx, hlt_nx;
  logic       load_use, detect, resolve, id_stall, halt_go;
  assign state = st;
  assign fwd_a = (mem_reg_write && mem_dst == ex_rs && ex_rs != '0) ? 2'b10 :
                 (wb_reg_write && wb_dst == ex_rs && ex_rs != '0) ? 2'b01 : 2'b00;
  assign fwd_b = (mem_reg_write && mem_dst == ex_rt && ex_rt != '0) ? 2'b10 :
                 (wb_reg_write && wb_dst == ex_rt && ex_rt != '0) ? 2'b01 : 2'b00;
  assign fwd_mem_data = M2M & mem_mem_write & wb_reg_write & (wb_dst == mem_rt) & (wb_dst != '0);
  // a store whose data comes from a load can take it from WB later, so only the address side stalls
  assign load_use = ex_mem_read & (ex_rt != '0) &
                    ((id_uses_rs & (ex_rt == id_rs)) | (id_uses_rt & (ex_rt == id_rt) & ~(id_mem_write & M2M)));
  // rflag marks the resolve cycle after BR_WAIT so the same branch is not detected twice
  assign detect   = (st == RUN) & ~rflag & id_is_cond_branch & ~load_use;
  assign resolve  = (st == RUN) & (rflag | (BR0 & detect));
  assign id_stall = load_use | (st == BR_WAIT) | (st == DRAIN) | (detect & ~BR0);
  assign halt_go  = (st == RUN) & id_is_halt & ~id_stall;
  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    idex_wen    = 1'b1;
    exmem_wen   = 1'b1;
    memwb_wen   = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (dcache_miss) begin
      {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} = '0;
    end else if (st == HALTED || id_stall) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_bubble = 1'b1;
    end else if (icache_miss) begin
      pc_wen     = 1'b0;
      ifid_flush = 1'b1;
    end else if (resolve && branch_taken) begin
      ifid_flush = 1'b1;
    end else if (halt_go) begin
      pc_wen = 1'b0;
    end
  end
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    rflag_nx = rflag;
    hlt_nx   = hlt;
    if (!dcache_miss) begin
      rflag_nx = 1'b0;
      case (st)
        RUN:
          if (detect && !BR0) begin
            st_nx  = BR_WAIT;
            cnt_nx = BR_INIT;
          end else if (halt_go) begin
            st_nx  = DRAIN;
            cnt_nx = DR_INIT;
          end
        BR_WAIT:
          if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
          else begin
            st_nx    = RUN;
            rflag_nx = 1'b1;
          end
        DRAIN:
          if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
          else begin
            st_nx  = HALTED;
            hlt_nx = 1'b1;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= RUN;
      cnt   <= 4'd0;
      rflag <= 1'b0;
      hlt   <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      rflag <= rflag_nx;
      hlt   <= hlt_nx;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized checks of pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int RA_W = 4, BSC = 2, DRN = 3, M2M = 1;
  logic clk = 0, rst_n = 0;
  logic [RA_W-1:0] id_rs, id_rt, ex_rs, ex_rt, mem_dst, mem_rt, wb_dst;
  logic id_uses_rs, id_uses_rt, id_mem_write, id_is_cond_branch, id_is_halt, branch_taken;
  logic ex_mem_read, mem_reg_write, mem_mem_write, wb_reg_write, icache_miss, dcache_miss;
  logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_bubble, fwd_mem_data, hlt;
  logic [1:0] fwd_a, fwd_b, state;
  int checks = 0, errors = 0;
  int br_left, drain_left;
  bit res_pend, halted, m_hlt;
  bit lu, running, detect, resolve, stall, halt_go;
  bit e_pc, e_ifid, e_down, e_flush, e_bub;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.RA_W(RA_W), .BR_STALL_CYC(BSC), .DRAIN_CYC(DRN), .FWD_M2M(M2M)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mem_write(id_mem_write), .id_is_cond_branch(id_is_cond_branch),
    .id_is_halt(id_is_halt), .branch_taken(branch_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .mem_mem_write(mem_mem_write), .mem_rt(mem_rt), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
    .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem_data(fwd_mem_data),
    .hlt(hlt), .state(state));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int fwd(input int r);
    if (r == 0) return 0;
    if (mem_reg_write && int'(mem_dst) == r) return 2;
    if (wb_reg_write && int'(wb_dst) == r) return 1;
    return 0;
  endfunction
  task automatic model_reset();
    br_left = 0; drain_left = 0; res_pend = 0; halted = 0; m_hlt = 0;
  endtask
  function automatic int m_state();
    return halted ? 3 : drain_left > 0 ? 2 : br_left > 0 ? 1 : 0;
  endfunction
  task automatic model_eval();
    lu = ex_mem_read && ex_rt != 0 && ((id_uses_rs && ex_rt == id_rs) ||
         (id_uses_rt && ex_rt == id_rt && !(id_mem_write && M2M != 0)));
    running = !halted && drain_left == 0 && br_left == 0;
    detect  = running && !res_pend && id_is_cond_branch && !lu;
    resolve = running && (res_pend || (BSC == 0 && detect));
    stall   = lu || br_left > 0 || drain_left > 0 || (detect && BSC > 0);
    halt_go = running && id_is_halt && !stall;
    {e_pc, e_ifid, e_down, e_flush, e_bub} = 5'b11100;
    if (dcache_miss) {e_pc, e_ifid, e_down} = 3'b000;
    else if (halted || stall) {e_pc, e_ifid, e_bub} = 3'b001;
    else if (icache_miss) {e_pc, e_flush} = 2'b01;
    else if (resolve && branch_taken) e_flush = 1;
    else if (halt_go) e_pc = 0;
  endtask
  task automatic model_adv();
    if (dcache_miss || halted) return;
    if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) begin halted = 1; m_hlt = 1; end
    end else if (br_left > 0) begin
      br_left--;
      res_pend = (br_left == 0);
    end else begin
      res_pend = 0;
      if (detect && BSC > 0) br_left = BSC;
      else if (halt_go) drain_left = DRN;
    end
  endtask
  task automatic step();
    @(negedge clk);
    model_eval();
    check("pc_wen", pc_wen, e_pc);
    check("ifid_wen", ifid_wen, e_ifid);
    check("idex_wen", idex_wen, e_down);
    check("exmem_wen", exmem_wen, e_down);
    check("memwb_wen", memwb_wen, e_down);
    check("ifid_flush", ifid_flush, e_flush);
    check("idex_bubble", idex_bubble, e_bub);
    check("fwd_a", fwd_a, fwd(ex_rs));
    check("fwd_b", fwd_b, fwd(ex_rt));
    check("fwd_mem_data", fwd_mem_data,
          (M2M != 0 && mem_mem_write && wb_reg_write && wb_dst == mem_rt && wb_dst != 0) ? 1 : 0);
    check("hlt", hlt, m_hlt);
    check("state", state, m_state());
    @(posedge clk);
    model_adv();
    #1;
  endtask
  task automatic idle();
    {id_rs, id_rt, ex_rs, ex_rt, mem_dst, mem_rt, wb_dst} = '0;
    {id_uses_rs, id_uses_rt, id_mem_write, id_is_cond_branch, id_is_halt, branch_taken} = '0;
    {ex_mem_read, mem_reg_write, mem_mem_write, wb_reg_write, icache_miss, dcache_miss} = '0;
  endtask
  task automatic async_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_hlt", hlt, 0);
    check("rst_state", state, 0);
    #1 rst_n = 1;
  endtask
  task automatic branch_seq(input bit taken);
    idle(); id_is_cond_branch = 1;
    #1 check("br_detect_bubble", idex_bubble, 1);
    step(); check("br_wait1", state, 1);
    step(); check("br_wait2", state, 1);
    step(); check("br_back_run", state, 0);
    branch_taken = taken;
    #1 check("br_resolve_flush", ifid_flush, taken);
    check("br_resolve_pc", pc_wen, 1);
    step(); idle();
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", state, 0);
    check("reset_hlt", hlt, 0);
    rst_n = 1;
    @(posedge clk); #1;
    mem_reg_write = 1; mem_dst = 3; wb_reg_write = 1; wb_dst = 3; ex_rs = 3;
    #1 check("plan_fwd_mem", fwd_a, 2);
    mem_reg_write = 0;
    #1 check("plan_fwd_wb", fwd_a, 1);
    ex_rs = 0;
    #1 check("plan_fwd_rf", fwd_a, 0);
    step();
    idle(); ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    #1 check("plan_lu_pc", pc_wen, 0);
    check("plan_lu_bubble", idex_bubble, 1);
    step(); ex_mem_read = 0;
    #1 check("plan_lu_one_cycle", pc_wen, 1);
    step();
    idle(); ex_mem_read = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1; id_mem_write = 1;
    #1 check("plan_store_no_stall", pc_wen, 1);
    step();
    idle(); mem_mem_write = 1; mem_rt = 5; wb_reg_write = 1; wb_dst = 5;
    #1 check("plan_fwd_mem_data", fwd_mem_data, 1);
    step();
    branch_seq(1);
    branch_seq(0);
    idle(); id_is_cond_branch = 1;
    step(); idle(); dcache_miss = 1;
    repeat (4) begin
      #1 check("plan_dc_pc", pc_wen, 0);
      check("plan_dc_memwb", memwb_wen, 0);
      step(); check("plan_dc_state", state, 1);
    end
    dcache_miss = 0;
    step(); check("plan_dc_wait_left", state, 1);
    step(); check("plan_dc_done", state, 0);
    step();
    idle(); id_is_halt = 1;
    step(); idle();
    check("plan_drain", state, 2);
    step(); step();
    check("plan_hlt_early", hlt, 0);
    step();
    check("plan_hlt", hlt, 1);
    check("plan_halted", state, 3);
    check("plan_halted_pc", pc_wen, 0);
    step();
    async_reset();
    idle(); icache_miss = 1;
    #1 check("plan_ic_pc", pc_wen, 0);
    check("plan_ic_flush", ifid_flush, 1);
    check("plan_ic_memwb", memwb_wen, 1);
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    #1 check("plan_ic_lu_ifid", ifid_wen, 0);
    check("plan_ic_lu_flush", ifid_flush, 0);
    step();
    for (int i = 0; i < 3000; i++) begin
      id_rs = RA_W'($urandom_range(0, 3)); id_rt = RA_W'($urandom_range(0, 3));
      ex_rs = RA_W'($urandom_range(0, 3)); ex_rt = RA_W'($urandom_range(0, 3));
      mem_dst = RA_W'($urandom_range(0, 3)); mem_rt = RA_W'($urandom_range(0, 3));
      wb_dst = RA_W'($urandom_range(0, 3));
      {id_uses_rs, id_uses_rt, id_mem_write, branch_taken} = 4'($urandom);
      {ex_mem_read, mem_reg_write, mem_mem_write, wb_reg_write} = 4'($urandom);
      id_is_cond_branch = ($urandom_range(0, 5) == 0);
      id_is_halt = ($urandom_range(0, 39) == 0);
      icache_miss = ($urandom_range(0, 5) == 0);
      dcache_miss = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0 || (halted && $urandom_range(0, 9) == 0)) async_reset();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised stall, flush and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It replaces the ad-hoc hazard, forwarding and branch-stall flops.
- Generalised over register-address width, branch-resolution wait length and halt-drain depth.
- Adds cache-miss freeze (I-side and D-side) and a halt-drain state machine with a clean final hlt.
- Sits beside the pipeline registers and drives all of their write-enable, flush and bubble controls, plus the EX and MEM forwarding muxes.

Parameters:
- RA_W, 4, register address width.
- BR_STALL_CYC, 1, ID stall cycles before a conditional branch resolves (0..15; 0 means resolve in the detect cycle).
- DRAIN_CYC, 3, cycles from halt leaving ID until hlt asserts (1..15).
- FWD_M2M, 1, enable WB-to-MEM store-data forwarding (0: store-data hazards stall in ID instead).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  RA_W  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID reads that source
- id_mem_write  in  1  ID is a store (id_rt is the store data)
- id_is_cond_branch  in  1  ID is B/BR with condition != always
- id_is_halt  in  1  ID opcode is HLT
- branch_taken  in  1  PC control resolves taken (valid in resolve cycle)
- ex_rs, ex_rt  in  RA_W  EX source registers
- ex_mem_read  in  1  EX is a load (dest = ex_rt)
- mem_reg_write  in  1  MEM writes a register
- mem_dst  in  RA_W  MEM destination
- mem_mem_write  in  1  MEM is a store
- mem_rt  in  RA_W  MEM store-data register
- wb_reg_write  in  1  WB writes a register
- wb_dst  in  RA_W  WB destination
- icache_miss, dcache_miss  in  1  memory not ready this cycle
- pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1  pipeline register enables
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  zero ID/EX control fields
- fwd_a, fwd_b  out  2  EX operand select: 10 = MEM, 01 = WB, 00 = register file
- fwd_mem_data  out  1  store data from WB
- hlt  out  1  halt complete (registered)
- state  out  2  00 RUN, 01 BR_WAIT, 10 DRAIN, 11 HALTED

Behaviour:
- Reset (async, rst_n = 0): state = RUN, counter = 0, hlt = 0. All other outputs are combinational from state and inputs.
- Forwarding (combinational, register 0 never matches):
  - fwd_a = 10 if mem_reg_write & mem_dst == ex_rs.
  - Otherwise fwd_a = 01 if wb_reg_write & wb_dst == ex_rs.
  - Otherwise fwd_a = 00. fwd_b is the same rule using ex_rt.
  - fwd_mem_data = FWD_M2M & mem_mem_write & wb_reg_write & wb_dst == mem_rt (wb_dst nonzero).
- load_use = ex_mem_read & ex_rt != 0 & ((id_uses_rs & ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt & ~(id_mem_write & FWD_M2M))).
- Priority, highest first:
  1. dcache_miss: all five enables = 0, no flush, no bubble; state and counter frozen.
  2. HALTED: pc_wen = ifid_wen = 0, idex_bubble = 1, downstream enables = 1.
  3. Any ID stall (load_use, BR_WAIT, branch detect with BR_STALL_CYC > 0, DRAIN): pc_wen = ifid_wen = 0, idex_bubble = 1.
  4. icache_miss: pc_wen = 0, ifid_flush = 1.
  5. Resolve cycle with branch_taken = 1: ifid_flush = 1, pc_wen = 1.
- Otherwise all enables are 1 and there is no flush or bubble.
- FSM (advances only when dcache_miss = 0):
  - RUN + id_is_cond_branch + ~load_use:
    - If BR_STALL_CYC = 0, this cycle is the resolve cycle.
    - Otherwise stall, counter = BR_STALL_CYC-1, go to BR_WAIT.
  - BR_WAIT: stall. If counter != 0, decrement. If counter == 0, go to RUN with the resolve flag set. In the next cycle the branch is not re-detected, resolves, and the flag clears.
  - RUN + id_is_halt + no stall: the halt advances to EX (idex not bubbled), pc_wen = 0, counter = DRAIN_CYC-1, go to DRAIN.
  - DRAIN: decrement counter. At 0, go to HALTED and set hlt = 1 on the same edge.
  - HALTED: sticky until reset.
- A load_use conflict with a branch or halt in ID: load_use wins; detection is retried the next cycle.
- Reset mid-BR_WAIT or mid-DRAIN returns immediately to RUN with hlt = 0.

Test Plan:
- EX mem_dst = 3 (mem_reg_write = 1), WB wb_dst = 3, ex_rs = 3 -> fwd_a = 10. Clear mem_reg_write -> fwd_a = 01. Set ex_rs = 0 -> fwd_a = 00.
- ex_mem_read = 1, ex_rt = 5, id_rs = 5, id_uses_rs = 1 -> exactly one cycle of pc_wen = 0, ifid_wen = 0, idex_bubble = 1. Repeat as a store with id_rt = 5 and FWD_M2M = 1 -> no stall; the next cycle, with wb_dst = 5 and mem_rt = 5, fwd_mem_data = 1.
- BR_STALL_CYC = 2, conditional branch in ID -> 2 stall cycles (state 01), then resolve cycle. branch_taken = 1 gives ifid_flush = 1; branch_taken = 0 gives no flush.
- dcache_miss held 4 cycles during BR_WAIT -> all enables 0 and the counter is unchanged; after release the remaining wait completes.
- id_is_halt with DRAIN_CYC = 3 -> hlt rises 3 edges later, state = 11, pc_wen stays 0. Then rst_n pulsed low asynchronously -> hlt = 0 and state = 00 immediately.
- icache_miss = 1 alone -> pc_wen = 0, ifid_flush = 1, downstream enables 1. icache_miss together with load_use -> ifid_wen = 0 and ifid_flush = 0.
